host_interface: RTL

Front-end stage directly upstream of the accelerator core. It accepts one job as an 18-bit word stream from the host: a fixed header, then image data, then filter data. It latches the header into the core's configuration inputs and writes the image and filter words into accelerator memory through the core's interface write port. It then releases the core from reset, buffers the core's output words in a FIFO for the host, and re-arms for the next job.

---
 rtl/host_interface.sv | 352 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/host_interface.sv
// host_interface: loads one accelerator job from an 18-bit host word stream.
// The stream is a 9-word header, then image words, then filter words. Header
// fields are latched onto the core configuration outputs. Payload words are
// written to accelerator memory through the interface write port. The core is
// then released from reset, and its results are buffered in an output FIFO.
//
// Optional feature: define HOST_INTERFACE_CHECKSUM_EN to require a trailer word
// after the filter data. The trailer must equal the 18-bit wrapping sum of
// every header, image and filter word of the job.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_data/in_valid/in_ready        host job word stream
//   out_data/out_valid/out_ready     result words to the host (FIFO head)
//   image_dim .. filter_bias         latched job configuration for the core
//   interface_write_*                memory load port (one cycle after accept)
//   output_read_data/_valid          result stream from the core
//   accel_done                       core finished the job
//   accel_rst                        held reset for the core
//   busy, overflow, checksum_error   status (overflow/checksum_error sticky)
module host_interface #(
    parameter int unsigned OUT_FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [17:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  image_dim,
    output logic [8:0]  image_depth,
    output logic [15:0] image_memory_offset,
    output logic [15:0] filter_memory_offset,
    output logic [15:0] output_memory_offset,
    output logic [1:0]  filter_halfsize,
    output logic [2:0]  filter_stride,
    output logic [12:0] filter_length,
    output logic [17:0] filter_bias,
    output logic [15:0] interface_write_addr,
    output logic [17:0] interface_write_data,
    output logic        interface_write_en,
    output logic [1:0]  interface_write_sel,
    input  logic [17:0] output_read_data,
    input  logic        output_read_valid,
    input  logic        accel_done,
    output logic        accel_rst,
    output logic        busy,
    output logic        overflow,
    output logic        checksum_error
);

    localparam int unsigned WORD_W    = 18;
    localparam int unsigned CNT_W     = 25;
    localparam int unsigned HDR_WORDS = 9;
    localparam int unsigned PTR_W     = $clog2(OUT_FIFO_DEPTH);
    localparam int unsigned FCNT_W    = PTR_W + 1;

    typedef enum logic [2:0] {
        S_HEADER = 3'd0,
        S_IMAGE  = 3'd1,
        S_FILTER = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4
`ifdef HOST_INTERFACE_CHECKSUM_EN
        , S_CHECK = 3'd5
`endif
    } state_t;

    // State entered once the last payload word is accepted
`ifdef HOST_INTERFACE_CHECKSUM_EN
    localparam state_t S_AFTER = S_CHECK;
`else
    localparam state_t S_AFTER = S_RUN;
`endif

    state_t              state_q, state_d;
    logic [3:0]          hdr_cnt_q, hdr_cnt_d;
    logic [CNT_W-1:0]    pay_cnt_q, pay_cnt_d;
    logic [7:0]          image_dim_q, image_dim_d;
    logic [8:0]          image_depth_q, image_depth_d;
    logic [15:0]         image_off_q, image_off_d;
    logic [15:0]         filter_off_q, filter_off_d;
    logic [15:0]         output_off_q, output_off_d;
    logic [1:0]          halfsize_q, halfsize_d;
    logic [2:0]          stride_q, stride_d;
    logic [12:0]         filter_length_q, filter_length_d;
    logic [17:0]         bias_q, bias_d;
    logic [15:0]         wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic [1:0]          wr_sel_q, wr_sel_d;
    logic                accel_rst_q, accel_rst_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                overflow_q, overflow_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   fifo_mem [OUT_FIFO_DEPTH];
`ifdef HOST_INTERFACE_CHECKSUM_EN
    logic [WORD_W-1:0]   sum_q, sum_d;
    logic                cks_err_q, cks_err_d;
    logic                trailer_ok;
`endif

    logic             accept;
    logic             hdr_last;
    logic [CNT_W-1:0] n_words;
    logic             img_last;
    logic             flt_last;
    logic             push_req;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;

    assign accept    = in_valid & in_ready_q;
    assign hdr_last  = (hdr_cnt_q == 4'(HDR_WORDS - 1));
    // Image word count from the latched header; dims are stable before W8
    assign n_words   = CNT_W'(image_dim_q) * CNT_W'(image_dim_q) * CNT_W'(image_depth_q);
    assign img_last  = ((pay_cnt_q + CNT_W'(1)) == n_words);
    assign flt_last  = ((pay_cnt_q + CNT_W'(1)) == CNT_W'(filter_length_q));
`ifdef HOST_INTERFACE_CHECKSUM_EN
    assign trailer_ok = (in_data == sum_q);
`endif

    // Output FIFO control; a full FIFO still takes a push when popped the same cycle
    assign push_req  = output_read_valid & ((state_q == S_RUN) | (state_q == S_DRAIN));
    assign fifo_full = (count_q == FCNT_W'(OUT_FIFO_DEPTH));
    assign pop       = out_valid_q & out_ready;
    assign push      = push_req & (~fifo_full | pop);
    assign drop      = push_req & fifo_full & ~pop;

    always_comb begin : fifo_next
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + FCNT_W'(1);
        else if (!push && pop) count_d = count_q - FCNT_W'(1);
        out_valid_d = (count_d != '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_HEADER;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_HEADER: begin
                if (accept && hdr_last) begin
                    if (n_words != '0)              state_d = S_IMAGE;
                    else if (filter_length_q != '0) state_d = S_FILTER;
                    else                            state_d = S_AFTER;
                end
            end
            S_IMAGE: begin
                if (accept && img_last)
                    state_d = (filter_length_q != '0) ? S_FILTER : S_AFTER;
            end
            S_FILTER: begin
                if (accept && flt_last) state_d = S_AFTER;
            end
`ifdef HOST_INTERFACE_CHECKSUM_EN
            S_CHECK: begin
                if (accept) state_d = trailer_ok ? S_RUN : S_HEADER;
            end
`endif
            S_RUN: begin
                if (accel_done) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if ((count_q == '0) && !push) state_d = S_HEADER;
            end
            default: state_d = S_HEADER;
        endcase
    end

    // Output and datapath next values
    always_comb begin : outputs
        hdr_cnt_d       = hdr_cnt_q;
        pay_cnt_d       = pay_cnt_q;
        image_dim_d     = image_dim_q;
        image_depth_d   = image_depth_q;
        image_off_d     = image_off_q;
        filter_off_d    = filter_off_q;
        output_off_d    = output_off_q;
        halfsize_d      = halfsize_q;
        stride_d        = stride_q;
        filter_length_d = filter_length_q;
        bias_d          = bias_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        wr_sel_d        = wr_sel_q;
        // Follows RUN by one cycle so the last memory write lands first
        accel_rst_d     = (state_q != S_RUN);
        busy_d          = (state_d != S_HEADER);
        in_ready_d      = (state_d == S_HEADER) || (state_d == S_IMAGE) || (state_d == S_FILTER);
        overflow_d      = overflow_q | drop;
`ifdef HOST_INTERFACE_CHECKSUM_EN
        if (state_d == S_CHECK) in_ready_d = 1'b1;
        sum_d     = sum_q;
        cks_err_d = cks_err_q;
`endif
        case (state_q)
            S_HEADER: begin
                if (accept) begin
                    hdr_cnt_d = hdr_last ? 4'd0 : hdr_cnt_q + 4'd1;
`ifdef HOST_INTERFACE_CHECKSUM_EN
                    sum_d = (hdr_cnt_q == 4'd0) ? in_data : sum_q + in_data;
`endif
                    case (hdr_cnt_q)
                        4'd0:    image_dim_d     = in_data[7:0];
                        4'd1:    image_depth_d   = in_data[8:0];
                        4'd2:    image_off_d     = in_data[15:0];
                        4'd3:    filter_off_d    = in_data[15:0];
                        4'd4:    output_off_d    = in_data[15:0];
                        4'd5:    halfsize_d      = in_data[1:0];
                        4'd6:    stride_d        = in_data[2:0];
                        4'd7:    filter_length_d = in_data[12:0];
                        4'd8:    bias_d          = in_data;
                        default: ;
                    endcase
                end
            end
            S_IMAGE, S_FILTER: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = in_data;
                    if (state_q == S_IMAGE) begin
                        wr_addr_d = image_off_q + pay_cnt_q[15:0];
                        wr_sel_d  = 2'd0;
                        pay_cnt_d = img_last ? '0 : pay_cnt_q + CNT_W'(1);
                    end else begin
                        wr_addr_d = filter_off_q + pay_cnt_q[15:0];
                        wr_sel_d  = 2'd1;
                        pay_cnt_d = flt_last ? '0 : pay_cnt_q + CNT_W'(1);
                    end
`ifdef HOST_INTERFACE_CHECKSUM_EN
                    sum_d = sum_q + in_data;
`endif
                end
            end
`ifdef HOST_INTERFACE_CHECKSUM_EN
            S_CHECK: begin
                if (accept && !trailer_ok) cks_err_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt_q       <= '0;
            pay_cnt_q       <= '0;
            image_dim_q     <= '0;
            image_depth_q   <= '0;
            image_off_q     <= '0;
            filter_off_q    <= '0;
            output_off_q    <= '0;
            halfsize_q      <= '0;
            stride_q        <= '0;
            filter_length_q <= '0;
            bias_q          <= '0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            wr_sel_q        <= '0;
            accel_rst_q     <= 1'b1;
            busy_q          <= 1'b0;
            in_ready_q      <= 1'b0;
            overflow_q      <= 1'b0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            out_valid_q     <= 1'b0;
`ifdef HOST_INTERFACE_CHECKSUM_EN
            sum_q           <= '0;
            cks_err_q       <= 1'b0;
`endif
        end else begin
            hdr_cnt_q       <= hdr_cnt_d;
            pay_cnt_q       <= pay_cnt_d;
            image_dim_q     <= image_dim_d;
            image_depth_q   <= image_depth_d;
            image_off_q     <= image_off_d;
            filter_off_q    <= filter_off_d;
            output_off_q    <= output_off_d;
            halfsize_q      <= halfsize_d;
            stride_q        <= stride_d;
            filter_length_q <= filter_length_d;
            bias_q          <= bias_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            wr_sel_q        <= wr_sel_d;
            accel_rst_q     <= accel_rst_d;
            busy_q          <= busy_d;
            in_ready_q      <= in_ready_d;
            overflow_q      <= overflow_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            out_valid_q     <= out_valid_d;
`ifdef HOST_INTERFACE_CHECKSUM_EN
            sum_q           <= sum_d;
            cks_err_q       <= cks_err_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (!rst && push) fifo_mem[wr_ptr_q] <= output_read_data;
    end

    assign in_ready             = in_ready_q;
    assign out_data             = fifo_mem[rd_ptr_q];
    assign out_valid            = out_valid_q;
    assign image_dim            = image_dim_q;
    assign image_depth          = image_depth_q;
    assign image_memory_offset  = image_off_q;
    assign filter_memory_offset = filter_off_q;
    assign output_memory_offset = output_off_q;
    assign filter_halfsize      = halfsize_q;
    assign filter_stride        = stride_q;
    assign filter_length        = filter_length_q;
    assign filter_bias          = bias_q;
    assign interface_write_addr = wr_addr_q;
    assign interface_write_data = wr_data_q;
    assign interface_write_en   = wr_en_q;
    assign interface_write_sel  = wr_sel_q;
    assign accel_rst            = accel_rst_q;
    assign busy                 = busy_q;
    assign overflow             = overflow_q;
`ifdef HOST_INTERFACE_CHECKSUM_EN
    assign checksum_error       = cks_err_q;
`else
    assign checksum_error       = 1'b0;
`endif

endmodule
